// File: rtl/cond_assign_parser.sv
// ============================================================================
// Module      : cond_assign_parser
// Description : Streaming ASCII parser/evaluator for one-line conditional
//               assignments "if xk <op> C p <= A else p <= B ;".
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_assign_parser #(
    parameter int DATA_W   = 32,
    parameter int NUM_VARS = 4,
    parameter int SIGNED   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_VARS*DATA_W-1:0]   x_flat,
    input  logic [6:0]                   ascii_char,
    input  logic                         char_valid,
    output logic                         char_ready,
    output logic [DATA_W-1:0]            result,
    output logic                         result_valid,
    output logic                         cond_true,
    output logic                         err_valid,
    output logic [2:0]                   err_code,
    output logic                         busy
);

    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,  S_KW_F    = 5'd1,  S_VAR_X   = 5'd2,  S_VAR_IDX = 5'd3,
        S_OP1     = 5'd4,  S_OP2     = 5'd5,  S_NUM_C   = 5'd6,  S_P1      = 5'd7,
        S_ASN1    = 5'd8,  S_ASN1_EQ = 5'd9,  S_NUM_A   = 5'd10, S_KW_E    = 5'd11,
        S_KW_L    = 5'd12, S_KW_S    = 5'd13, S_KW_E2   = 5'd14, S_P2      = 5'd15,
        S_ASN2    = 5'd16, S_ASN2_EQ = 5'd17, S_NUM_B   = 5'd18, S_SEMI    = 5'd19,
        S_EVAL    = 5'd20, S_ERR     = 5'd21
    } state_t;

    localparam logic [2:0] OP_EQ = 3'd0, OP_NE = 3'd1, OP_LT = 3'd2,
                           OP_LE = 3'd3, OP_GT = 3'd4, OP_GE = 3'd5;

    localparam logic [6:0] CH_I = 7'h69, CH_F = 7'h66, CH_X = 7'h78, CH_P = 7'h70,
                           CH_E = 7'h65, CH_L = 7'h6C, CH_S = 7'h73, CH_LT = 7'h3C,
                           CH_GT = 7'h3E, CH_EQ = 7'h3D, CH_BANG = 7'h21,
                           CH_MINUS = 7'h2D, CH_SEMI = 7'h3B;

    localparam logic [3:0] NV = 4'(NUM_VARS);

    // Largest accepted magnitude; the accumulator carries 4 spare bits so
    // acc*10+9 never wraps before the comparison.
    localparam logic [DATA_W+3:0] MAX_MAG = (SIGNED != 0) ?
        {5'b0, {(DATA_W-1){1'b1}}} : {4'b0, {DATA_W{1'b1}}};

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W+3:0]   acc_q, acc_d;
    logic                neg_q, neg_d, dig_q, dig_d;
    logic [DATA_W-1:0]   c_q, c_d, a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                cond_true_q, cond_true_d;
    logic                err_valid_q, err_valid_d;
    logic [2:0]          err_code_q, err_code_d;

    logic [6:0]          ch;
    logic                xfer, is_ws, is_dig;
    logic [3:0]          dig_val;
    logic [DATA_W+3:0]   acc_next;
    logic [DATA_W-1:0]   num_val;
    logic [DATA_W-1:0]   x_sel;
    logic                lt, eq, take;
    state_t              disp;
    logic                tok, err;
    logic [2:0]          code;

    assign ch       = ascii_char;
    assign xfer     = char_valid && char_ready;
    assign is_ws    = (ch == 7'h20) || (ch == 7'h09) || (ch == 7'h0A) || (ch == 7'h0D);
    assign is_dig   = (ch >= 7'h30) && (ch <= 7'h39);
    assign dig_val  = ch[3:0];
    assign acc_next = (acc_q << 3) + (acc_q << 1) + {{DATA_W{1'b0}}, dig_val};
    assign num_val  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];

    always_comb begin
        x_sel = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            if (idx_q == 4'(k)) x_sel = x_flat[k*DATA_W +: DATA_W];
        end
    end

    assign eq = (x_sel == c_q);
    assign lt = (SIGNED != 0) ? ($signed(x_sel) < $signed(c_q)) : (x_sel < c_q);

    always_comb begin
        case (op_q)
            OP_EQ:   take = eq;
            OP_NE:   take = !eq;
            OP_LT:   take = lt;
            OP_LE:   take = lt || eq;
            OP_GT:   take = !(lt || eq);
            default: take = !lt;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        op_d           = op_q;
        acc_d          = acc_q;
        neg_d          = neg_q;
        dig_d          = dig_q;
        c_d            = c_q;
        a_d            = a_q;
        b_d            = b_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        cond_true_d    = cond_true_q;
        err_valid_d    = 1'b0;
        err_code_d     = err_code_q;
        disp           = state_q;
        tok            = 1'b0;
        err            = 1'b0;
        code           = 3'd1;

        if (state_q == S_EVAL) begin
            result_d       = take ? a_q : b_q;
            cond_true_d    = take;
            result_valid_d = 1'b1;
            state_d        = S_IDLE;
        end else if (xfer) begin
            // A lone '<' or '>' hands a non-'=' char straight to the constant.
            if (state_q == S_OP2 && (op_q == OP_LT || op_q == OP_GT) && ch != CH_EQ)
                disp = S_NUM_C;

            if (disp == S_NUM_C || disp == S_NUM_A || disp == S_NUM_B) begin
                if (is_dig) begin
                    if (acc_next > MAX_MAG) begin
                        err  = 1'b1;
                        code = 3'd2;
                    end else begin
                        acc_d   = acc_next;
                        dig_d   = 1'b1;
                        state_d = disp;
                    end
                end else if (ch == CH_MINUS && !dig_q && !neg_q) begin
                    if (SIGNED != 0) begin
                        neg_d   = 1'b1;
                        state_d = disp;
                    end else begin
                        err = 1'b1;
                    end
                end else if (is_ws && !dig_q) begin
                    if (neg_q) err = 1'b1;
                    else       state_d = disp;
                end else if (!dig_q) begin
                    err  = 1'b1;
                    code = 3'd4;
                end else begin
                    // Number complete: store it, then treat this char as the next token.
                    case (disp)
                        S_NUM_C: begin c_d = num_val; disp = S_P1;   end
                        S_NUM_A: begin a_d = num_val; disp = S_KW_E; end
                        default: begin b_d = num_val; disp = S_SEMI; end
                    endcase
                    acc_d = '0;
                    neg_d = 1'b0;
                    dig_d = 1'b0;
                    tok   = 1'b1;
                end
            end else begin
                tok = 1'b1;
            end

            if (tok) begin
                state_d = disp;
                case (disp)
                    S_IDLE:    if (ch == CH_I) state_d = S_KW_F; else if (!is_ws) err = 1'b1;
                    S_KW_F:    if (ch == CH_F) state_d = S_VAR_X; else err = 1'b1;
                    S_VAR_X:   if (ch == CH_X) state_d = S_VAR_IDX; else if (!is_ws) err = 1'b1;
                    S_VAR_IDX: begin
                        if (!is_dig) begin
                            err = 1'b1;
                        end else if (dig_val >= NV) begin
                            err  = 1'b1;
                            code = 3'd3;
                        end else begin
                            idx_d   = dig_val;
                            state_d = S_OP1;
                        end
                    end
                    S_OP1: begin
                        state_d = S_OP2;
                        if      (ch == CH_EQ)   op_d = OP_EQ;
                        else if (ch == CH_BANG) op_d = OP_NE;
                        else if (ch == CH_LT)   op_d = OP_LT;
                        else if (ch == CH_GT)   op_d = OP_GT;
                        else if (is_ws)         state_d = S_OP1;
                        else                    err = 1'b1;
                    end
                    S_OP2: begin
                        if (ch == CH_EQ) begin
                            if (op_q == OP_LT) op_d = OP_LE;
                            if (op_q == OP_GT) op_d = OP_GE;
                            state_d = S_NUM_C;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    S_P1:      if (ch == CH_P) state_d = S_ASN1; else if (!is_ws) err = 1'b1;
                    S_ASN1:    if (ch == CH_LT) state_d = S_ASN1_EQ; else if (!is_ws) err = 1'b1;
                    S_ASN1_EQ: if (ch == CH_EQ) state_d = S_NUM_A; else err = 1'b1;
                    S_KW_E:    if (ch == CH_E) state_d = S_KW_L; else if (!is_ws) err = 1'b1;
                    S_KW_L:    if (ch == CH_L) state_d = S_KW_S; else err = 1'b1;
                    S_KW_S:    if (ch == CH_S) state_d = S_KW_E2; else err = 1'b1;
                    S_KW_E2:   if (ch == CH_E) state_d = S_P2; else err = 1'b1;
                    S_P2:      if (ch == CH_P) state_d = S_ASN2; else if (!is_ws) err = 1'b1;
                    S_ASN2:    if (ch == CH_LT) state_d = S_ASN2_EQ; else if (!is_ws) err = 1'b1;
                    S_ASN2_EQ: if (ch == CH_EQ) state_d = S_NUM_B; else err = 1'b1;
                    S_SEMI:    if (ch == CH_SEMI) state_d = S_EVAL; else if (!is_ws) err = 1'b1;
                    S_ERR:     if (ch == CH_SEMI) state_d = S_IDLE;
                    default:   state_d = S_IDLE;
                endcase
            end

            // An offending ';' already ends the statement, so resync immediately.
            if (err) begin
                err_valid_d = 1'b1;
                err_code_d  = code;
                state_d     = (ch == CH_SEMI) ? S_IDLE : S_ERR;
            end
        end

        if (state_d == S_IDLE || state_d == S_ERR) begin
            acc_d = '0;
            neg_d = 1'b0;
            dig_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            op_q           <= OP_EQ;
            acc_q          <= '0;
            neg_q          <= 1'b0;
            dig_q          <= 1'b0;
            c_q            <= '0;
            a_q            <= '0;
            b_q            <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            cond_true_q    <= 1'b0;
            err_valid_q    <= 1'b0;
            err_code_q     <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            op_q           <= op_d;
            acc_q          <= acc_d;
            neg_q          <= neg_d;
            dig_q          <= dig_d;
            c_q            <= c_d;
            a_q            <= a_d;
            b_q            <= b_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            cond_true_q    <= cond_true_d;
            err_valid_q    <= err_valid_d;
            err_code_q     <= err_code_d;
        end
    end

    assign char_ready   = (state_q != S_EVAL);
    assign busy         = (state_q != S_IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign cond_true    = cond_true_q;
    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_cond_assign_parser.sv
// ============================================================================
// Module      : tb_cond_assign_parser
// Description : Directed bench for cond_assign_parser, unsigned and signed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_assign_parser;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] x_u, x_s;
    logic [6:0]   ch_u, ch_s;
    logic         vld_u, vld_s;
    logic         rdy_u, rdy_s, rv_u, rv_s, ct_u, ct_s, ev_u, ev_s, busy_u, busy_s;
    logic [31:0]  res_u, res_s;
    logic [2:0]   code_u, code_s;

    int n_tests = 0;
    int n_fail  = 0;
    int chars_sent = 0;
    int n_res_u = 0, n_err_u = 0, nrdy_u = 0, n_res_s = 0, n_err_s = 0;
    int last_pos_u = 0;
    logic [2:0]  last_code_u = '0;
    logic        last_ct_u = 1'b0, last_ct_s = 1'b0;
    logic [31:0] last_res_s = '0;
    logic [31:0] res_hist [16];

    always #5 clk = ~clk;

    cond_assign_parser #(.DATA_W(32), .NUM_VARS(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .x_flat(x_u), .ascii_char(ch_u), .char_valid(vld_u),
        .char_ready(rdy_u), .result(res_u), .result_valid(rv_u), .cond_true(ct_u),
        .err_valid(ev_u), .err_code(code_u), .busy(busy_u));

    cond_assign_parser #(.DATA_W(32), .NUM_VARS(4), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .x_flat(x_s), .ascii_char(ch_s), .char_valid(vld_s),
        .char_ready(rdy_s), .result(res_s), .result_valid(rv_s), .cond_true(ct_s),
        .err_valid(ev_s), .err_code(code_s), .busy(busy_s));

    always @(negedge clk) begin
        if (!rdy_u) nrdy_u++;
        if (rv_u) begin
            res_hist[n_res_u % 16] = res_u;
            last_ct_u = ct_u;
            n_res_u++;
        end
        if (ev_u) begin
            n_err_u++;
            last_code_u = code_u;
            last_pos_u  = chars_sent;
        end
        if (rv_s) begin
            last_res_s = res_s;
            last_ct_s  = ct_s;
            n_res_s++;
        end
        if (ev_s) n_err_s++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one char per accepted transfer; returns 1 time unit after the last edge.
    task automatic send(input string s, input bit sel);
        for (int i = 0; i < s.len(); i++) begin
            byte b;
            int  guard;
            b = s[i];
            guard = 0;
            @(negedge clk);
            while (!(sel ? rdy_s : rdy_u)) begin
                if (sel) vld_s = 1'b0; else vld_u = 1'b0;
                @(negedge clk);
                guard++;
                if (guard > 20) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ready_timeout: got 0 expected 1");
                    return;
                end
            end
            if (sel) begin ch_s = b[6:0]; vld_s = 1'b1; end
            else     begin ch_u = b[6:0]; vld_u = 1'b1; end
            @(posedge clk);
            #1;
            vld_u = 1'b0;
            vld_s = 1'b0;
            chars_sent++;
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base_r, base_e, base_n;
        rst   = 1'b1;
        vld_u = 1'b0;
        vld_s = 1'b0;
        ch_u  = '0;
        ch_s  = '0;
        x_u   = {32'd10, 32'd7, 32'hFFFF_FFFF, 32'd0};
        x_s   = {32'd0, 32'd0, 32'hFFFF_FFFD, 32'd0};
        repeat (2) @(negedge clk);
        check("rst_result", res_u, 0);
        check("rst_rv", rv_u, 0);
        check("rst_ct", ct_u, 0);
        check("rst_ev", ev_u, 0);
        check("rst_code", code_u, 0);
        check("rst_busy", busy_u, 0);
        check("rst_ready", rdy_u, 1);
        rst = 1'b0;

        // Basic statement with exact latency
        send("if x2>=7 p<=11 else p<=22;", 1'b0);
        @(negedge clk);
        check("eval_ready_low", rdy_u, 0);
        check("eval_rv_low", rv_u, 0);
        @(negedge clk);
        check("lat_rv", rv_u, 1);
        check("lat_result", res_u, 11);
        check("lat_ct", ct_u, 1);
        check("lat_ready", rdy_u, 1);
        check("lat_busy", busy_u, 0);
        @(negedge clk);
        check("rv_pulse", rv_u, 0);

        x_u[95:64] = 32'd6;
        send("if x2>=7 p<=11 else p<=22;", 1'b0);
        settle();
        check("else_result", res_u, 22);
        check("else_ct", last_ct_u, 0);

        // Back-to-back, one stall cycle each
        base_r = n_res_u;
        base_n = nrdy_u;
        send("if x0<5p<=1 else p<=2;if x0!=0 p<=3 else p<=4;", 1'b0);
        settle();
        check("b2b_count", n_res_u - base_r, 2);
        check("b2b_first", res_hist[base_r % 16], 1);
        check("b2b_second", res_hist[(base_r + 1) % 16], 4);
        check("b2b_stalls", nrdy_u - base_n, 2);

        // Variable index out of range
        base_r = n_res_u;
        base_e = n_err_u;
        chars_sent = 0;
        send("if x5==1 p<=1 else p<=2;", 1'b0);
        settle();
        check("idx_err_count", n_err_u - base_e, 1);
        check("idx_err_code", last_code_u, 3);
        check("idx_err_pos", last_pos_u, 5);
        check("idx_no_result", n_res_u - base_r, 0);
        send("if x0==0 p<=9 else p<=8;", 1'b0);
        settle();
        check("resync_result", res_u, 9);
        check("resync_ct", last_ct_u, 1);

        // Overflow on the final digit
        base_e = n_err_u;
        chars_sent = 0;
        send("if x0==4294967296 p<=1 else p<=2;", 1'b0);
        settle();
        check("ovf_count", n_err_u - base_e, 1);
        check("ovf_code", last_code_u, 2);
        check("ovf_pos", last_pos_u, 17);

        // Empty number
        chars_sent = 0;
        send("if x0== p<=1 else p<=2;", 1'b0);
        settle();
        check("empty_code", last_code_u, 4);
        check("empty_pos", last_pos_u, 9);

        // Bad char in IDLE, then recovery
        base_e = n_err_u;
        chars_sent = 0;
        send("q;if x3>9 p<=7 else p<=8;", 1'b0);
        settle();
        check("idle_bad_count", n_err_u - base_e, 1);
        check("idle_bad_code", last_code_u, 1);
        check("idle_bad_pos", last_pos_u, 1);
        check("idle_recover", res_u, 7);

        // Largest unsigned value accepted
        send("if x1==4294967295 p<=4294967295 else p<=0;", 1'b0);
        settle();
        check("max_result", res_u, 32'hFFFF_FFFF);
        check("max_ct", last_ct_u, 1);

        // Minus sign rejected when unsigned
        chars_sent = 0;
        send("if x0<-2 p<=1 else p<=2;", 1'b0);
        settle();
        check("uminus_code", last_code_u, 1);
        check("uminus_pos", last_pos_u, 7);

        // Signed compare with negative constants
        base_r = n_res_s;
        send("if x1<-2 p<=-1 else p<=5;", 1'b1);
        settle();
        check("signed_count", n_res_s - base_r, 1);
        check("signed_result", last_res_s, 32'hFFFF_FFFF);
        check("signed_ct", last_ct_s, 1);
        check("signed_no_err", n_err_s, 0);
        send("if x1>=-2 p<=-1 else p<=5;", 1'b1);
        settle();
        check("signed_else", last_res_s, 5);
        check("signed_else_ct", last_ct_s, 0);

        // Reset mid-statement
        send("if x0==12", 1'b0);
        @(negedge clk);
        check("mid_busy", busy_u, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy_u, 0);
        check("mid_rst_ready", rdy_u, 1);
        check("mid_rst_result", res_u, 0);
        check("mid_rst_ct", ct_u, 0);
        check("mid_rst_code", code_u, 0);
        check("mid_rst_rv", rv_u, 0);
        check("mid_rst_ev", ev_u, 0);
        @(negedge clk);
        rst = 1'b0;
        send("if x0==0 p<=3 else p<=4;", 1'b0);
        settle();
        check("post_rst_result", res_u, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
